// File: rtl/dpu_instr_prefetch.sv
// Instruction prefetch: streams num_words from base_addr into a small FIFO
// and hands them to the core over instr_vld/instr_rdy.
// Ports: clk, rst_n (async low); start/base_addr/num_words launch a block;
// busy/done status; mem_rd_en/mem_rd_addr/mem_rd_data read port (1-cycle
// latency); instr_out/instr_vld/instr_rdy core side.
// Macro PREFETCH_PERF_CNT_EN adds the stall_cycles output.
module dpu_instr_prefetch #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_vld,
  input  logic              instr_rdy
`ifdef PREFETCH_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, num_q, issued_q;
  logic              inflight_q;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_q, occ;
  logic              push, pop, last_pop, drained;

  assign push      = inflight_q;
  assign instr_vld = (count_q != '0);
  assign pop       = instr_vld & instr_rdy;
  assign instr_out = instr_vld ? fifo_mem[rd_ptr] : '0;

  assign occ       = count_q + CW'(inflight_q);
  assign mem_rd_en = (state_q == S_FETCH) &&
                     (issued_q < num_q) &&
                     (occ < CW'(FIFO_DEPTH));
  assign mem_rd_addr = base_q + issued_q;

  assign busy = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);

  // Look ahead to the final pop so done lands the cycle right after it.
  assign last_pop = pop && (count_q == CW'(1));
  assign drained  = !inflight_q &&
                    ((count_q == '0) || last_pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (start)
          state_d = (num_words == '0) ? S_DONE : S_FETCH;
      S_FETCH:
        if (mem_rd_en && (issued_q + ADDR_W'(1) == num_q))
          state_d = S_DRAIN;
      S_DRAIN:
        if (drained) state_d = S_DONE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= mem_rd_en;
      if (state_q == S_IDLE && start) begin
        base_q   <= base_addr;
        num_q    <= num_words;
        issued_q <= '0;
      end else if (mem_rd_en) begin
        issued_q <= issued_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef PREFETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (state_q == S_IDLE && start)
      stall_cycles <= '0;
    else if (busy && instr_vld && !instr_rdy &&
             stall_cycles != '1)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_dpu_instr_prefetch.sv
// Scoreboard bench for dpu_instr_prefetch: expected words/addresses are
// queued at launch and a negedge monitor checks what the DUT presents.
module tb_dpu_instr_prefetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr, num_words;
  logic        busy, done, mem_rd_en;
  logic [15:0] mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic [31:0] instr_out;
  logic        instr_vld, instr_rdy;
`ifdef PREFETCH_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  dpu_instr_prefetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .num_words   (num_words),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .instr_out   (instr_out),
    .instr_vld   (instr_vld),
    .instr_rdy   (instr_rdy)
`ifdef PREFETCH_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory returns addr + 0xA000 one cycle after the request.
  always @(posedge clk)
    if (mem_rd_en)
      mem_rd_data <= {16'h0, mem_rd_addr} + 32'hA000;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] addr_q[$];
  logic [31:0] data_q[$];
  int issued, popped, max_occ, done_cnt;
  int start_cyc, first_hs, last_hs, cur_num;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h at cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (issued - popped > max_occ)
        max_occ = issued - popped;
      if (mem_rd_en) begin
        chk("occ_limit", 32'(issued - popped < 4), 32'd1);
        if (addr_q.size() == 0)
          chk("extra_read", {16'h0, mem_rd_addr}, 32'hFFFFFFFF);
        else
          chk("rd_addr", {16'h0, mem_rd_addr},
              {16'h0, addr_q.pop_front()});
        issued++;
      end
      if (instr_vld && instr_rdy) begin
        if (data_q.size() == 0)
          chk("extra_word", instr_out, 32'hFFFFFFFF);
        else
          chk("instr_out", instr_out, data_q.pop_front());
        if (popped == 0) begin
          first_hs = cyc;
          chk("first_lat", 32'(cyc - start_cyc), 32'd2);
        end
        popped++;
        last_hs = cyc;
      end
      if (done) begin
        done_cnt++;
        chk("done_time", 32'(cyc),
            32'(cur_num == 0 ? start_cyc : last_hs + 1));
      end
    end
  end

  task automatic xfer(input logic [15:0] b,
                      input logic [15:0] n,
                      input int s_at,
                      input int s_len,
                      input bit extra,
                      input int abort_at);
    int off;
    logic [15:0] a;
    done_cnt = 0; popped = 0; issued = 0; max_occ = 0;
    cur_num = int'(n);
    for (int i = 0; i < int'(n); i++) begin
      a = b + 16'(i);
      addr_q.push_back(a);
      data_q.push_back({16'h0, a} + 32'hA000);
    end
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; num_words = n;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
    for (int k = 0; k < 300 && done_cnt == 0; k++) begin
      off = cyc - start_cyc;
      instr_rdy = !(off >= s_at && off < s_at + s_len);
      if (extra && off == 3) begin
        start = 1'b1; base_addr = 16'h0500; num_words = 16'd6;
      end else begin
        start = 1'b0;
      end
      if (abort_at > 0 && popped == abort_at) begin
        rst_n = 1'b0;
        #2;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_rd_en", {31'b0, mem_rd_en}, 32'd0);
        chk("rst_addr", {16'h0, mem_rd_addr}, 32'd0);
        chk("rst_vld", {31'b0, instr_vld}, 32'd0);
        chk("rst_out", instr_out, 32'd0);
        start = 1'b0;
        instr_rdy = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    instr_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("words_popped", 32'(popped), 32'(n));
    chk("data_left", 32'(data_q.size()), 32'd0);
    chk("addr_left", 32'(addr_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; instr_rdy = 1'b1;
    base_addr = '0; num_words = '0;
    #12;
    chk("r_busy", {31'b0, busy}, 32'd0);
    chk("r_done", {31'b0, done}, 32'd0);
    chk("r_rd_en", {31'b0, mem_rd_en}, 32'd0);
    chk("r_addr", {16'h0, mem_rd_addr}, 32'd0);
    chk("r_vld", {31'b0, instr_vld}, 32'd0);
    chk("r_out", instr_out, 32'd0);
`ifdef PREFETCH_PERF_CNT_EN
    chk("r_stall", stall_cycles, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    xfer(16'h0010, 16'd8, 0, 0, 1'b0, 0);
    chk("stream_rate", 32'(last_hs - first_hs), 32'd7);

    xfer(16'h0040, 16'd16, 6, 10, 1'b0, 0);
    chk("bp_max_occ", 32'(max_occ), 32'd4);
`ifdef PREFETCH_PERF_CNT_EN
    chk("stall_cycles", stall_cycles, 32'd10);
`endif

    xfer(16'h0000, 16'd0, 0, 0, 1'b0, 0);
    chk("zero_reads", 32'(issued), 32'd0);

    xfer(16'hFFFE, 16'd4, 0, 0, 1'b0, 0);

    xfer(16'h0300, 16'd6, 0, 0, 1'b1, 0);

    xfer(16'h0100, 16'd8, 0, 0, 1'b0, 3);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_done", 32'(done_cnt), 32'd0);
    addr_q.delete();
    data_q.delete();
    rst_n = 1'b1;
    xfer(16'h0200, 16'd2, 0, 0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
